// File: rtl/ddr_pkg.sv
// Shared types for the chart sequencer: one chart entry, the end marker and the FSM states.
package ddr_pkg;
  localparam int LANES = 4;
  localparam int DUR_W = 4;

  typedef struct packed {
    logic [LANES-1:0] arrows;
    logic [DUR_W-1:0] dur;
  } chart_entry_t;

  localparam logic [DUR_W-1:0] END_MARKER = '0;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_DONE} seq_state_e;
endpackage

// File: rtl/chart_sequencer.sv
// Walks a chart ROM one entry per step and fires arrow-spawn events on sixteenth-note ticks.
module chart_sequencer #(
  parameter int LANES  = ddr_pkg::LANES,
  parameter int DUR_W  = ddr_pkg::DUR_W,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   pause_i,
  input  logic                   sixteenth_i,
  output logic [ADDR_W-1:0]      rom_addr_o,
  input  logic [LANES+DUR_W-1:0] rom_data_i,
  output logic                   spawn_valid_o,
  output logic [LANES-1:0]       spawn_arrows_o,
  input  logic                   spawn_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o,
  output logic [CNT_W-1:0]       tick_count_o
);
  import ddr_pkg::*;

  seq_state_e       state;
  logic [DUR_W-1:0] countdown;
  logic             tick_pending;
  logic [LANES-1:0] ent_arrows;
  logic [DUR_W-1:0] ent_dur;

  logic [LANES-1:0] rom_arrows;
  logic [DUR_W-1:0] rom_dur;
  logic             raw_tick;
  logic             eff_tick;
  logic             fire;
  logic             spawn_fire;

  assign rom_arrows = rom_data_i[LANES+DUR_W-1:DUR_W];
  assign rom_dur    = rom_data_i[DUR_W-1:0];
  assign raw_tick   = sixteenth_i & ~pause_i;
  assign eff_tick   = (sixteenth_i | tick_pending) & ~pause_i;
  assign fire       = (state == S_WAIT) && eff_tick && (countdown == DUR_W'(1));
  assign spawn_fire = fire && (ent_arrows != '0);

  // rom_addr_o doubles as the chart pointer; it only moves when an entry fires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      rom_addr_o   <= '0;
      countdown    <= DUR_W'(1);
      tick_pending <= 1'b0;
      tick_count_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      ent_arrows   <= '0;
      ent_dur      <= '0;
    end else if (start_i) begin
      state        <= S_FETCH;
      rom_addr_o   <= '0;
      countdown    <= DUR_W'(1);
      tick_pending <= 1'b0;
      tick_count_o <= '0;
      busy_o       <= 1'b1;
      done_o       <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (raw_tick) tick_pending <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: begin
          if (raw_tick) tick_pending <= 1'b1;
          ent_arrows <= rom_arrows;
          ent_dur    <= rom_dur;
          if (rom_dur == DUR_W'(END_MARKER)) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eff_tick) begin
            tick_pending <= 1'b0;
            tick_count_o <= tick_count_o + CNT_W'(1);
            if (countdown == DUR_W'(1)) begin
              countdown  <= ent_dur;
              rom_addr_o <= rom_addr_o + ADDR_W'(1);
              state      <= S_FETCH;
            end else begin
              countdown <= countdown - DUR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A spawn landing on a stalled output is dropped in favour of the one already held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spawn_valid_o  <= 1'b0;
      spawn_arrows_o <= '0;
      overrun_o      <= 1'b0;
    end else if (start_i) begin
      spawn_valid_o  <= 1'b0;
      spawn_arrows_o <= '0;
      overrun_o      <= 1'b0;
    end else if (spawn_fire) begin
      if (!spawn_valid_o || spawn_ready_i) begin
        spawn_valid_o  <= 1'b1;
        spawn_arrows_o <= ent_arrows;
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (spawn_valid_o && spawn_ready_i) begin
      spawn_valid_o <= 1'b0;
    end
  end
endmodule

// File: doc/chart_sequencer.md
Name: chart_sequencer

Overview:
- Sits directly downstream of the note-timing tick generator; consumes its sixteenth-note tick.
- Walks a chart stored in an external synchronous ROM, one entry per step, and fires arrow-spawn events to the scroller/display on exact sixteenth-note boundaries.
- Each chart entry is {arrows, duration}: arrows spawn on the entry's tick; duration is the number of sixteenths until the next entry fires.

Parameters:
- LANES, 4, arrow lanes (bits per arrow mask)
- DUR_W, 4, duration field width in sixteenths
- ADDR_W, 8, chart ROM address width (chart depth 2**ADDR_W)
- CNT_W, 16, width of tick_count_o

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  pulse: start chart from address 0 (aborts any run in progress)
- pause_i  in  1  level: while high, sixteenth ticks are ignored
- sixteenth_i  in  1  one-cycle tick from the timing block
- rom_addr_o  out  ADDR_W  chart ROM address
- rom_data_i  in  LANES+DUR_W  ROM data, valid 1 cycle after address; format {arrows[LANES-1:0], dur[DUR_W-1:0]}
- spawn_valid_o  out  1  arrow-spawn event valid
- spawn_arrows_o  out  LANES  lane mask of the spawn event
- spawn_ready_i  in  1  consumer accepts the spawn (valid&ready)
- busy_o  out  1  sequencer running (FETCH/LOAD/WAIT)
- done_o  out  1  level: end-of-chart reached; held until next start_i
- overrun_o  out  1  sticky: a spawn was dropped; cleared on start_i
- tick_count_o  out  CNT_W  sixteenth ticks consumed since start; wraps modulo 2**CNT_W

Behaviour:
- Reset (async, rst_ni low): state IDLE, rom_addr_o=0, spawn_valid_o=0, spawn_arrows_o=0, busy_o=0, done_o=0, overrun_o=0, tick_count_o=0, countdown=1, tick_pending=0.
- States: IDLE, FETCH, LOAD, WAIT, DONE.
- IDLE/DONE: start_i -> FETCH with addr=0, countdown=1, tick_count=0, tick_pending=0, overrun=0, done=0; sixteenth_i ignored.
- FETCH: rom_addr_o=addr; unconditionally -> LOAD next cycle.
- LOAD: latch rom_data_i; dur==0 is the end marker -> DONE (done_o=1 from the next cycle); else -> WAIT.
- WAIT:
  - Effective tick = (sixteenth_i | tick_pending) & !pause_i; tick_pending clears when consumed.
  - On an effective tick: tick_count++.
  - If countdown==1, the entry fires: countdown<=dur, addr++, -> FETCH.
  - Otherwise countdown--.
  - Firing an entry with arrows==0 (rest) produces no spawn.
- Ticks during FETCH/LOAD with pause_i low set tick_pending (one-deep). A second tick while pending is lost. Tick period must be >=4 cycles.
- Timing: entry 0 fires on the first tick after start; entry k+1 fires exactly dur_k ticks after entry k. The last note's duration is not waited out.
- Spawn output:
  - Registered; spawn_valid_o rises the cycle after the firing tick.
  - spawn_valid_o and spawn_arrows_o hold stable until spawn_ready_i; valid drops the cycle after the handshake.
  - If a new spawn fires while spawn_valid_o=1 and spawn_ready_i=0, the new spawn is dropped, the old spawn is kept, and overrun_o is set.
  - If it fires in the handshake cycle, the new spawn loads (back-to-back accepted).
- Address wrap: addr increments past 2**ADDR_W-1 back to 0; chart authors must terminate the chart with an end marker.
- start_i while busy: abort immediately. A pending spawn is cleared; restart as from IDLE.
- start_i has priority over a simultaneous tick.
- busy_o = state in {FETCH, LOAD, WAIT}.

Decomposition:
- Shared package ddr_pkg holds:
  - LANES and DUR_W constants
  - packed struct chart_entry_t {arrows, dur}
  - END_MARKER (dur==0) constant
  - state enum seq_state_e
- No sub-module required. The spawn output register with its overrun logic is one small always_ff block. The ROM stays external.

Test Plan:
- Chart {0x12, 0x01, 0xA3, 0x00}, ticks every 10 cycles, ready=1:
  - spawn 0001 at tick0+1 cycle, no spawn at tick1 or tick2, spawn 1010 at tick3+1;
  - done_o high 3 cycles after tick3; tick_count_o=4.
- pause_i high across two ticks mid-chart -> those ticks are not counted; spawn timing shifts by exactly 2 ticks; tick_count_o excludes them.
- spawn_ready_i held low for 3 ticks with entries {0x11, 0x21, 0x41, 0x00} -> spawn_arrows_o stays 0001, overrun_o=1; after ready, valid drops next cycle.
- Tick asserted in the FETCH cycle (tick period 4) -> tick pended, and the entry fires on time in WAIT. Two ticks within FETCH/LOAD -> exactly one counted.
- start_i pulsed during WAIT at chart address 2 -> rom_addr_o=0 next cycle, overrun_o/tick_count_o cleared, pending spawn dropped, chart replays from entry 0.
- rst_ni asserted low mid-spawn (spawn_valid_o=1) -> all outputs 0 asynchronously. After release, the block stays IDLE and ignores ticks until start_i.
